// File: rtl/whack_game_if.sv
// Port bundle between the reaction-game sequencer and its surroundings:
// tick and start in, raw switches in, LED drive and BCD score digits out.
interface whack_game_if #(
    parameter int LED_NUM = 8
);
    logic               tick;
    logic               start;
    logic [LED_NUM-1:0] switch;
    logic [LED_NUM-1:0] led_state;
    logic [15:0]        nums;
    logic               busy;
    logic               hit_pulse;
    logic               game_over;

    modport master (
        output tick, start, switch,
        input  led_state, nums, busy, hit_pulse, game_over
    );

    modport slave (
        input  tick, start, switch,
        output led_state, nums, busy, hit_pulse, game_over
    );
endinterface

// File: rtl/whack_game_ctrl.sv
// Reaction-game sequencer: lights one pseudo-random LED per round, scores a
// rising edge on the matching switch inside a tick-counted window, keeps BCD scores.
module whack_game_ctrl #(
    parameter int LED_NUM   = 8,
    parameter int TIMEOUT   = 6,
    parameter int GAP_TICKS = 2,
    parameter int ROUNDS    = 10
) (
    input  logic        clk,
    input  logic        clr,
    whack_game_if.slave game
);
    localparam int         LW         = $clog2(LED_NUM);
    localparam logic [7:0] LFSR_SEED  = 8'hA5;
    localparam logic [7:0] TIMEOUT_V  = 8'(TIMEOUT);
    localparam logic [7:0] GAP_V      = 8'(GAP_TICKS);
    localparam logic [7:0] ROUNDS_BCD = 8'(((ROUNDS / 10) * 16) + (ROUNDS % 10));

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_HIT,
        S_MISS,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [LW-1:0]      target_q, target_d;
    logic [7:0]         timer_q, timer_d;
    logic [7:0]         gap_q, gap_d;
    logic [7:0]         rounds_q, rounds_d;
    logic [7:0]         hits_q, hits_d;

    logic [LED_NUM-1:0] sync1_q, sync2_q, prev_q, edge_q;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               busy_q, busy_d;
    logic               hit_q, hit_d;
    logic               over_q, over_d;

    logic [LED_NUM-1:0] tgt_hot;
    logic [LED_NUM-1:0] tgt_hot_next;
    logic [7:0]         lfsr_step;
    logic [LW-1:0]      cand;
    logic [7:0]         rounds_inc;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // One-hot views of the current target (hit classification) and the
    // upcoming target (registered LED drive).
    for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_dec
        assign tgt_hot[gi]      = (target_q == LW'(gi));
        assign tgt_hot_next[gi] = (target_d == LW'(gi));
    end

    assign lfsr_step  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign cand       = lfsr_step[LW-1:0];
    assign rounds_inc = bcd_inc(rounds_q);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        target_d = target_q;
        timer_d  = timer_q;
        gap_d    = gap_q;
        rounds_d = rounds_q;
        hits_d   = hits_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (game.start) begin
                    rounds_d = 8'h00;
                    hits_d   = 8'h00;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                // target_q still holds the previous round's LED here
                lfsr_d   = lfsr_step;
                target_d = (cand == target_q) ? cand + 1'b1 : cand;
                timer_d  = TIMEOUT_V;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (game.tick) begin
                    timer_d = timer_q - 8'd1;
                end
                // Any switch activity decides the round before the timer does.
                if (|edge_q) begin
                    state_d = (edge_q == tgt_hot) ? S_HIT : S_MISS;
                end else if (game.tick && (timer_q == 8'd1)) begin
                    state_d = S_MISS;
                end
            end
            S_HIT, S_MISS: begin
                rounds_d = rounds_inc;
                if (state_q == S_HIT) begin
                    hits_d = bcd_inc(hits_q);
                end
                if (rounds_inc == ROUNDS_BCD) begin
                    state_d = S_DONE;
                end else if (GAP_TICKS == 0) begin
                    state_d = S_ARM;
                end else begin
                    gap_d   = GAP_V;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (game.tick) begin
                    gap_d = gap_q - 8'd1;
                    if (gap_q == 8'd1) begin
                        state_d = S_ARM;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        led_d  = '0;
        busy_d = 1'b1;
        hit_d  = 1'b0;
        over_d = 1'b0;
        case (state_d)
            S_WAIT: led_d = tgt_hot_next;
            S_DONE: led_d = '1;
            default: led_d = '0;
        endcase
        if ((state_d == S_IDLE) || (state_d == S_DONE)) begin
            busy_d = 1'b0;
        end
        hit_d  = (state_d == S_HIT);
        over_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            timer_q  <= 8'd0;
            gap_q    <= 8'd0;
            rounds_q <= 8'h00;
            hits_q   <= 8'h00;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            led_q    <= '0;
            busy_q   <= 1'b0;
            hit_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            rounds_q <= rounds_d;
            hits_q   <= hits_d;
            sync1_q  <= game.switch;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            edge_q   <= sync2_q & ~prev_q;
            led_q    <= led_d;
            busy_q   <= busy_d;
            hit_q    <= hit_d;
            over_q   <= over_d;
        end
    end

    assign game.led_state = led_q;
    assign game.nums      = {rounds_q, hits_q};
    assign game.busy      = busy_q;
    assign game.hit_pulse = hit_q;
    assign game.game_over = over_q;
endmodule
